min_ls1u: RTL and testbench

Minimal LS1u system block: a tiny 8-bit accumulator CPU fused with an FSB8 multiplexed-bus master, forming the whole "MIN" SoC. All code and data come from external memory over the FSB8 bus: a 24-bit address is multiplexed onto AAH8/AD8, and an external 74373-style latch captures it on the busclk edge while ale_n is low. It serves as the smallest bring-up configuration of the LS1u family.

---
 rtl/min_ls1u.sv | 174 +++++++++++++++++
 tb/tb_min_ls1u.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/min_ls1u.sv
// min_ls1u: 8-bit accumulator CPU fused with an FSB8 multiplexed-bus master.
// Define LS1U_IRQ_EN to build the interrupt logic (IE, EPC, RETI); otherwise irq_n is ignored.
module min_ls1u (
  input  logic       sysclk,
  input  logic       sysrst,
  output logic       busclk,
  output logic       busrst_n,
  output logic       ale_n,
  output logic       cs_n,
  output logic       cmd_n,
  output logic       typ,
  output logic       wr_n,
  input  logic       rdy_n,
  input  logic       irq_n,
  inout  wire  [7:0] AD8,
  output logic [7:0] AAH8
);
  typedef enum logic [2:0] {P_RST, P_SYNC, P_T1, P_T2, P_T3, P_HALT} ph_e;
  typedef enum logic [1:0] {X_OP, X_IMM, X_RD, X_WR} xf_e;
  ph_e ph_q, ph_d;
  xf_e xf_q, xf_d;
  logic clk_q, brst_q, rdy_q;
  logic [7:0] a_q, a_d, pc_q, pc_d, imm_q, imm_d, din_q, reti_pc, alu;
  logic [15:0] dp_q, dp_d;
  logic [3:0] op_q, op_d;
  logic z_q, z_d, c_q, c_d, halt_q, halt_d;
  logic fall, rise, bnd, irq_take, dat, t1, t2, t3;
  logic [8:0] sum, dif;
  // State advances only on edges that drive busclk low; inputs are sampled on busclk rising edges.
  assign fall = brst_q & clk_q;
  assign rise = brst_q & ~clk_q;
  assign bnd  = fall & (ph_q == P_SYNC || ph_q == P_HALT || (ph_q == P_T3 && xf_q == X_OP && !halt_q));
  assign sum  = {1'b0, a_q} + {1'b0, din_q};
  assign dif  = {1'b0, a_q} - {1'b0, din_q};
  assign alu  = op_q == 4'h2 ? din_q :
                op_q == 4'h4 ? sum[7:0] :
                op_q == 4'h5 ? dif[7:0] :
                op_q == 4'h6 ? (a_q & din_q) :
                op_q == 4'h7 ? (a_q | din_q) : (a_q ^ din_q);
`ifdef LS1U_IRQ_EN
  logic ie_q, ie_d, reti;
  logic [7:0] epc_q, epc_d;
  assign reti     = fall && ph_q == P_T2 && !rdy_q && xf_q == X_IMM && op_q == 4'hE;
  assign irq_take = bnd & ie_q & ~irq_n;
  assign ie_d     = irq_take ? 1'b0 : reti ? 1'b1 : ie_q;
  assign epc_d    = irq_take ? pc_q : epc_q;
  assign reti_pc  = epc_q;
  always_ff @(posedge sysclk or posedge sysrst)
    if (sysrst) begin
      ie_q  <= 1'b1;
      epc_q <= 8'h00;
    end else begin
      ie_q  <= ie_d;
      epc_q <= epc_d;
    end
`else
  logic unused_irq;
  assign unused_irq = irq_n;
  assign irq_take   = 1'b0;
  assign reti_pc    = pc_q + 8'd2;
`endif
  always_comb begin
    ph_d   = ph_q;
    xf_d   = xf_q;
    a_d    = a_q;
    pc_d   = pc_q;
    imm_d  = imm_q;
    dp_d   = dp_q;
    op_d   = op_q;
    z_d    = z_q;
    c_d    = c_q;
    halt_d = halt_q;
    if (fall) begin
      case (ph_q)
        P_RST:  ph_d = P_SYNC;
        P_SYNC: ph_d = P_T1;
        P_T1:   ph_d = P_T2;
        P_T2:
          if (!rdy_q) begin
            ph_d = P_T3;
            case (xf_q)
              X_OP: begin
                op_d = din_q[7:4];
                xf_d = X_IMM;
              end
              X_IMM: begin
                imm_d = din_q;
                pc_d  = pc_q + 8'd2;
                xf_d  = X_OP;
                case (op_q)
                  4'h1: begin
                    a_d = din_q;
                    z_d = din_q == 8'h00;
                  end
                  4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: xf_d = X_RD;
                  4'h3: xf_d = X_WR;
                  4'h9: pc_d = din_q;
                  4'hA: pc_d = z_q ? din_q : pc_q + 8'd2;
                  4'hB: pc_d = c_q ? din_q : pc_q + 8'd2;
                  4'hC: dp_d[7:0] = din_q;
                  4'hD: dp_d[15:8] = din_q;
                  4'hE: pc_d = reti_pc;
                  4'hF: halt_d = 1'b1;
                  default: ;
                endcase
              end
              X_RD: begin
                a_d  = alu;
                z_d  = alu == 8'h00;
                c_d  = op_q == 4'h4 ? sum[8] : op_q == 4'h5 ? dif[8] : c_q;
                xf_d = X_OP;
              end
              default: xf_d = X_OP;
            endcase
          end
        P_T3:   ph_d = halt_q ? P_HALT : P_T1;
        P_HALT: ph_d = irq_take ? P_T1 : P_HALT;
        default: ph_d = P_RST;
      endcase
      if (irq_take) begin
        ph_d   = P_T1;
        pc_d   = 8'h80;
        halt_d = 1'b0;
        xf_d   = X_OP;
      end
    end
  end
  always_ff @(posedge sysclk or posedge sysrst)
    if (sysrst) begin
      clk_q  <= 1'b0;
      brst_q <= 1'b0;
      ph_q   <= P_RST;
      xf_q   <= X_OP;
      a_q    <= 8'h00;
      pc_q   <= 8'h00;
      imm_q  <= 8'h00;
      dp_q   <= 16'h0000;
      op_q   <= 4'h0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      halt_q <= 1'b0;
      rdy_q  <= 1'b1;
      din_q  <= 8'h00;
    end else begin
      clk_q  <= ~clk_q;
      brst_q <= 1'b1;
      ph_q   <= ph_d;
      xf_q   <= xf_d;
      a_q    <= a_d;
      pc_q   <= pc_d;
      imm_q  <= imm_d;
      dp_q   <= dp_d;
      op_q   <= op_d;
      z_q    <= z_d;
      c_q    <= c_d;
      halt_q <= halt_d;
      if (rise) rdy_q <= rdy_n;
      if (rise && ph_q == P_T2 && !rdy_n) din_q <= AD8;
    end
  assign t1       = ph_q == P_T1;
  assign t2       = ph_q == P_T2;
  assign t3       = ph_q == P_T3;
  assign dat      = xf_q == X_RD || xf_q == X_WR;
  assign busclk   = clk_q;
  assign busrst_n = brst_q;
  assign typ      = 1'b0;
  assign ale_n    = ~t1;
  assign cs_n     = ~t2;
  assign cmd_n    = ~((t1 | t2 | t3) & ~dat);
  assign wr_n     = ~(t2 && xf_q == X_WR);
  assign AAH8     = t1 ? (dat ? dp_q[15:8] : 8'h00) :
                    t2 ? (dat ? imm_q : pc_q + {7'b0, xf_q == X_IMM}) : 8'h00;
  assign AD8      = t1 ? (dat ? dp_q[7:0] : 8'h00) : !wr_n ? a_q : 8'hzz;
endmodule

// File: tb/tb_min_ls1u.sv
// tb_min_ls1u: FSB8 memory target plus scoreboard of expected bus transactions for min_ls1u.
module tb_min_ls1u;
  logic sysclk = 1'b0, sysrst = 1'b0, rdy_n = 1'b1, irq_n = 1'b1;
  logic busclk, busrst_n, ale_n, cs_n, cmd_n, typ, wr_n;
  logic [7:0] AAH8, rd_data = 8'h00;
  logic [15:0] lat = 16'h0000;
  wire [7:0] AD8;
  logic [7:0] mem [logic [23:0]];
  logic [33:0] obs_q[$], exp_q[$];
  int checks = 0, errs = 0;

  min_ls1u dut (.sysclk(sysclk), .sysrst(sysrst), .busclk(busclk), .busrst_n(busrst_n),
                .ale_n(ale_n), .cs_n(cs_n), .cmd_n(cmd_n), .typ(typ), .wr_n(wr_n),
                .rdy_n(rdy_n), .irq_n(irq_n), .AD8(AD8), .AAH8(AAH8));

  always #5 sysclk = ~sysclk;
  assign AD8 = (!cs_n && wr_n) ? rd_data : 8'hzz;

  function automatic logic [7:0] rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  always @(negedge sysclk) rd_data = rd({lat, AAH8});

  // Transaction record: {cmd_n, wr_n, address[23:0], data}
  always @(posedge busclk) begin
    if (!ale_n) lat = {AAH8, AD8};
    if (!cs_n && !rdy_n) begin
      if (!wr_n) mem[{lat, AAH8}] = AD8;
      obs_q.push_back({cmd_n, wr_n, lat, AAH8, wr_n ? rd_data : AD8});
    end
  end

  task automatic chk(input string tag, input logic [33:0] o, input logic [33:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s got=%h want=%h", tag, o, e);
    end
  endtask

  task automatic ef(input logic [7:0] pc);
    exp_q.push_back({2'b01, 16'h0000, pc, rd({16'h0000, pc})});
  endtask
  task automatic efs(input logic [7:0] pc, input int n);
    for (int i = 0; i < n; i++) ef(pc + 8'(i));
  endtask
  task automatic er(input logic [23:0] a);
    exp_q.push_back({2'b11, a, rd(a)});
  endtask
  task automatic ew(input logic [23:0] a, input logic [7:0] d);
    exp_q.push_back({2'b10, a, d});
  endtask
  task automatic ld(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1);
    mem[a] = d0;
    mem[a + 24'd1] = d1;
  endtask

  task automatic drain(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      logic [33:0] e;
      t = 0;
      while (obs_q.size() == 0 && t < 300) begin
        @(negedge sysclk);
        t++;
      end
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk($sformatf("%s_avail%0d", tag, k), 34'(obs_q.size() != 0), 34'd1);
      if (obs_q.size() != 0) chk($sformatf("%s%0d", tag, k), obs_q.pop_front(), e);
    end
  endtask

  task automatic rst_on();
    @(negedge sysclk);
    sysrst = 1'b1;
    mem.delete();
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic rst_off();
    repeat (2) @(negedge sysclk);
    sysrst = 1'b0;
  endtask

  initial begin
    rst_on();
    #1;
    chk("rst_out", {busclk, busrst_n, ale_n, cs_n, cmd_n, typ, wr_n, AAH8},
        {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00});
    rst_off();
    @(posedge sysclk);
    #1;
    chk("brst_rel", {busrst_n, busclk}, 2'b11);
    for (int i = 0; i < 20 && ale_n !== 1'b0; i++) @(negedge sysclk);
    chk("t1", {ale_n, cs_n, cmd_n, AAH8, AD8}, {1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
    for (int i = 0; i < 20 && cs_n !== 1'b0; i++) @(negedge sysclk);
    repeat (20) @(negedge sysclk);
    chk("stall_bus", {ale_n, cs_n, wr_n, AAH8}, {1'b1, 1'b0, 1'b1, 8'h00});
    chk("stall_nocyc", 34'(obs_q.size()), 34'd0);
    rdy_n = 1'b0;
    ef(8'h00);
    drain("boot", 1);

    rst_on();
    ld(24'h0, 8'h10, 8'h5A);
    ld(24'h2, 8'h30, 8'h20);
    rst_off();
    efs(8'h00, 4);
    ew(24'h000020, 8'h5A);
    ef(8'h04);
    drain("st", 6);
    chk("mem20", rd(24'h000020), 8'h5A);

    rst_on();
    ld(24'h0, 8'hD0, 8'h12);
    ld(24'h2, 8'hC0, 8'h34);
    ld(24'h4, 8'h20, 8'h56);
    ld(24'h6, 8'h30, 8'h00);
    mem[24'h123456] = 8'hA5;
    rst_off();
    efs(8'h00, 6);
    er(24'h123456);
    efs(8'h06, 2);
    ew(24'h123400, 8'hA5);
    drain("dp", 10);

    rst_on();
    ld(24'h00, 8'h10, 8'hF0);
    ld(24'h02, 8'h40, 8'h20);
    ld(24'h04, 8'hA0, 8'h30);
    ld(24'h06, 8'hB0, 8'h40);
    ld(24'h40, 8'h30, 8'h21);
    ld(24'h42, 8'h50, 8'h22);
    ld(24'h44, 8'hB0, 8'h48);
    ld(24'h48, 8'h70, 8'h23);
    ld(24'h4A, 8'h30, 8'h24);
    ld(24'h4C, 8'h80, 8'h25);
    ld(24'h4E, 8'hA0, 8'h50);
    ld(24'h50, 8'h30, 8'h26);
    mem[24'h20] = 8'h20;
    mem[24'h22] = 8'h11;
    mem[24'h25] = 8'hFF;
    rst_off();
    efs(8'h00, 4);
    er(24'h20);
    efs(8'h04, 4);
    efs(8'h40, 2);
    ew(24'h21, 8'h10);
    efs(8'h42, 2);
    er(24'h22);
    efs(8'h44, 2);
    efs(8'h48, 2);
    er(24'h23);
    efs(8'h4A, 2);
    ew(24'h24, 8'hFF);
    efs(8'h4C, 2);
    er(24'h25);
    efs(8'h4E, 2);
    efs(8'h50, 2);
    ew(24'h26, 8'h00);
    drain("alu", 31);

    rst_on();
    ld(24'h00, 8'h90, 8'hFE);
    ld(24'hFE, 8'h10, 8'h77);
    rst_off();
    efs(8'h00, 2);
    efs(8'hFE, 2);
    efs(8'h00, 2);
    drain("wrap", 6);

    rst_on();
    ld(24'h00, 8'h90, 8'h10);
    ld(24'h10, 8'hF0, 8'h00);
    ld(24'h12, 8'hF0, 8'h00);
    ld(24'h80, 8'hE0, 8'h00);
    rst_off();
    efs(8'h00, 2);
    efs(8'h10, 2);
    drain("halt", 4);
    repeat (40) @(negedge sysclk);
    chk("halt_idle", 34'(obs_q.size()), 34'd0);
`ifdef LS1U_IRQ_EN
    irq_n = 1'b0;
    ef(8'h80);
    drain("irq", 1);
    irq_n = 1'b1;
    ef(8'h81);
    efs(8'h12, 2);
    drain("reti", 3);
    repeat (20) @(negedge sysclk);
    chk("halt2_idle", 34'(obs_q.size()), 34'd0);
    irq_n = 1'b0;
    ef(8'h80);
    drain("ie_again", 1);
    irq_n = 1'b1;

    rst_on();
    ld(24'h00, 8'h10, 8'h11);
    ld(24'h02, 8'h30, 8'h50);
    ld(24'h80, 8'hE0, 8'h00);
    rst_off();
    ef(8'h00);
    drain("late", 1);
    irq_n = 1'b0;
    ef(8'h01);
    ef(8'h80);
    drain("late", 2);
    irq_n = 1'b1;
    ef(8'h81);
    efs(8'h02, 2);
    ew(24'h50, 8'h11);
    drain("late_ret", 4);
`else
    irq_n = 1'b0;
    repeat (60) @(negedge sysclk);
    chk("halt_hold", 34'(obs_q.size()), 34'd0);
    irq_n = 1'b1;

    rst_on();
    ld(24'h00, 8'hE0, 8'h00);
    ld(24'h02, 8'h10, 8'h33);
    ld(24'h04, 8'h30, 8'h40);
    rst_off();
    efs(8'h00, 6);
    ew(24'h40, 8'h33);
    drain("reti_nop", 7);
`endif

    rst_on();
    ld(24'h00, 8'h10, 8'hAB);
    ld(24'h02, 8'h30, 8'h60);
    rst_off();
    for (int i = 0; i < 200 && wr_n !== 1'b0; i++) @(negedge sysclk);
    chk("wr_seen", {cmd_n, wr_n, AAH8}, {1'b1, 1'b0, 8'h60});
    sysrst = 1'b1;
    #1;
    chk("rst_mid", {busclk, busrst_n, ale_n, cs_n, cmd_n, typ, wr_n, AAH8},
        {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00});
    chk("no_write", rd(24'h60), 8'h00);
    obs_q.delete();
    exp_q.delete();
    rst_off();
    ef(8'h00);
    drain("restart", 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
